vmem_stage: RTL
===============

VMEM_STAGE -- requirements
Module: vmem_stage

Interface
REQ-001 Parameter ADDR_W, default 10: data-memory word-address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 regmem_M  input  1  vector load request in the memory stage.
REQ-005 memw_M  input  1  vector store request in the memory stage.
REQ-006 ALUrslt_M  input  128  effective address; bits [31:0] are the byte address, bits [127:32] are unused.
REQ-007 writedata_M  input  128  store data; lane k is bits [32k+31:32k].
REQ-008 readdata_M  output  128  assembled load data, feeding the memory-writeback pipe register.
REQ-009 stall_M  output  1  freezes the PC and all upstream pipe registers and holds the memory-writeback pipe register.
REQ-010 mem_addr  output  ADDR_W  word address to the single-port synchronous RAM.
REQ-011 mem_data  output  32  RAM write data.
REQ-012 mem_wren  output  1  RAM write enable.
REQ-013 mem_q  input  32  RAM read data, valid one cycle after its address is presented.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, LWAIT, STORE and DONE.
REQ-015 In IDLE with regmem_M=1 at cycle T, the block SHALL latch base = ALUrslt_M[ADDR_W+1:4], assert stall_M and enter LOAD.
REQ-016 LOAD SHALL last 4 cycles (T+1..T+4) and present mem_addr={base,beat} for beat 0..3.
REQ-017 mem_q SHALL be captured into lane beat-1 during LOAD beats 1..3, and lane 3 SHALL be captured in LWAIT (T+5).
REQ-018 DONE (T+6) SHALL drive stall_M=0 with readdata_M showing the complete vector; the total load stall is 6 cycles (T..T+5).
REQ-019 In IDLE with memw_M=1 and regmem_M=0 at cycle T, the block SHALL latch base and writedata_M, assert stall_M and enter STORE.
REQ-020 STORE SHALL last 4 cycles (T+1..T+4) with mem_wren=1, mem_addr={base,beat} and mem_data=lane beat, then enter DONE at T+5; the total store stall is 5 cycles.
REQ-021 DONE SHALL ignore regmem_M and memw_M, drive stall_M=0 and return to IDLE.
REQ-022 If regmem_M and memw_M are both 1, the load SHALL take priority and the store SHALL be dropped.
REQ-023 ALUrslt_M[3:0] SHALL be ignored (16-byte aligned access); the address SHALL wrap modulo 2^ADDR_W words.
REQ-024 Changes on ALUrslt_M and writedata_M after acceptance SHALL have no effect.
REQ-025 readdata_M SHALL be updated only by a completed load and SHALL hold its value through stores and idle cycles.
REQ-026 In IDLE with no request, stall_M SHALL be 0 and mem_wren SHALL be 0.
REQ-027 mem_wren SHALL be 0 in every state except STORE.
REQ-028 When no beat is active, mem_addr and mem_data SHALL be 0.

Reset
REQ-029 rst=1 SHALL force state=IDLE, beat=0, stall_M=0, mem_wren=0, readdata_M=0, mem_addr=0 and mem_data=0 on the next edge.
REQ-030 A reset asserted in the middle of an operation SHALL abort it; store beats already written SHALL remain in the RAM and no further beats SHALL be written.

Configuration
REQ-031 With macro VMEM_ALIGN_CHECK_EN defined, the block SHALL add output align_err (1 bit), asserted only in DONE when the latched ALUrslt_M[3:0] is nonzero.
REQ-032 Under VMEM_ALIGN_CHECK_EN, a misaligned store SHALL keep mem_wren=0 for all 4 beats, and a misaligned load SHALL leave readdata_M unchanged; the stall timing SHALL be unchanged.
REQ-033 Without VMEM_ALIGN_CHECK_EN, align_err SHALL be absent and REQ-023 SHALL apply.

Structure
REQ-034 Package vmem_pkg SHALL hold the state enum, BEATS=4, LANE_W=32 and VEC_W=128.
REQ-035 The beat counter and lane assembly SHALL be implemented inline; no sub-module is required.

Verification
REQ-036 Load test: preload words 0x40..0x43 with 0x11111111..0x44444444, then load with ALUrslt_M=0x100 -> stall_M high for exactly 6 cycles; readdata_M=0x44444444_33333333_22222222_11111111 in DONE.
REQ-037 Store test: store with ALUrslt_M=0x200 and writedata_M=0x0000FFFF -> mem_wren high for 4 cycles at addresses 0x80..0x83 with data 0x0000FFFF,0,0,0; stall_M high for 5 cycles.
REQ-038 Simultaneous request: regmem_M=1 and memw_M=1 -> load sequence only; mem_wren never asserted.
REQ-039 Reset mid-operation: rst=1 at STORE beat 2 -> only addresses +0 and +1 written; stall_M=0 and readdata_M=0 on the next cycle.
REQ-040 Back-to-back: load then an immediate store, with the store presented at DONE -> the store is ignored in DONE, accepted in the following IDLE cycle, and readdata_M holds the loaded value.
REQ-041 Wrap: ALUrslt_M=0xFFF0 with ADDR_W=10 -> addresses 0x3FC..0x3FF; under VMEM_ALIGN_CHECK_EN, ALUrslt_M=0x104 -> align_err=1 in DONE and no write.

Source files
------------

// File: rtl/vmem_pkg.sv
// vmem_pkg -- shared types and sizes for the vector memory stage.
// A 128-bit vector is moved as four 32-bit lanes, one lane per RAM beat.
package vmem_pkg;

  localparam int BEATS  = 4;
  localparam int LANE_W = 32;
  localparam int VEC_W  = 128;
  localparam int BEAT_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LWAIT,
    STORE,
    DONE
  } state_t;

  // Pick lane idx (0 = least significant) out of a vector.
  function automatic logic [LANE_W-1:0] vec_lane(input logic [VEC_W-1:0]  vec,
                                                 input logic [BEAT_W-1:0] idx);
    return LANE_W'(vec >> (LANE_W * int'(idx)));
  endfunction

endpackage

// File: rtl/vmem_stage.sv
// vmem_stage -- memory-stage sequencer that serialises a 128-bit vector load
// or store into four 32-bit beats on a single-port synchronous RAM, holding
// the pipeline with stall_M while the beats run.
// Build option: define VMEM_ALIGN_CHECK_EN to add align_err and suppress the
// RAM writes / result update of accesses whose address is not 16-byte aligned.
module vmem_stage
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regmem_M,
  input  logic              memw_M,
  input  logic [VEC_W-1:0]  ALUrslt_M,
  input  logic [VEC_W-1:0]  writedata_M,
  output logic [VEC_W-1:0]  readdata_M,
  output logic              stall_M,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [LANE_W-1:0] mem_q
`ifdef VMEM_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  state_t                  state;
  state_t                  state_next;
  logic [BEAT_W-1:0]       beat;
  logic [ADDR_W-3:0]       base;
  logic [VEC_W-1:0]        wdata;
  logic [VEC_W-LANE_W-1:0] load_buf;
  logic                    suppress;
  logic                    unused_addr_bits;

  // Only the 16-byte-block index of the byte address selects RAM words.
  assign unused_addr_bits = ^{ALUrslt_M[VEC_W-1:ADDR_W+2], ALUrslt_M[3:0]};

`ifdef VMEM_ALIGN_CHECK_EN
  logic misalign_q;

  // Remember whether the accepted address had nonzero low nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (state == IDLE && (regmem_M || memw_M)) begin
      misalign_q <= |ALUrslt_M[3:0];
    end
  end

  assign suppress  = misalign_q;
  assign align_err = (state == DONE) && misalign_q;
`else
  assign suppress = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and RAM-side outputs; reset blocks any write in its cycle so an aborted store stops at once.
  always_comb begin
    state_next = state;
    stall_M    = 1'b0;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    case (state)
      IDLE: begin
        if (regmem_M) begin
          stall_M    = 1'b1;
          state_next = LOAD;
        end else if (memw_M) begin
          stall_M    = 1'b1;
          state_next = STORE;
        end
      end
      LOAD: begin
        stall_M  = 1'b1;
        mem_addr = {base, beat};
        if (beat == BEAT_W'(BEATS - 1)) begin
          state_next = LWAIT;
        end
      end
      LWAIT: begin
        stall_M    = 1'b1;
        state_next = DONE;
      end
      STORE: begin
        stall_M  = 1'b1;
        mem_addr = {base, beat};
        mem_data = vec_lane(wdata, beat);
        mem_wren = !rst && !suppress;
        if (beat == BEAT_W'(BEATS - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request latching, beat counting and lane assembly; readdata_M only changes when a load completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat       <= '0;
      base       <= '0;
      wdata      <= '0;
      load_buf   <= '0;
      readdata_M <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (regmem_M || memw_M) begin
            base  <= ALUrslt_M[ADDR_W+1:4];
            wdata <= writedata_M;
          end
        end
        LOAD: begin
          beat <= beat + 1'b1;
          case (beat)
            2'd1:    load_buf[LANE_W-1:0]          <= mem_q;
            2'd2:    load_buf[2*LANE_W-1:LANE_W]   <= mem_q;
            2'd3:    load_buf[3*LANE_W-1:2*LANE_W] <= mem_q;
            default: ;
          endcase
        end
        LWAIT: begin
          beat <= '0;
          if (!suppress) begin
            readdata_M <= {mem_q, load_buf};
          end
        end
        STORE: begin
          beat <= beat + 1'b1;
        end
        default: begin
          beat <= '0;
        end
      endcase
    end
  end

endmodule
